// File: rtl/acc_rr_scheduler.sv
// Round-robin shared-adder accumulator bank: NUM_CH private accumulators, one add per cycle.
// Latency: add lands in acc at the grant edge; rd_data/rd_ovf and grant_valid/grant_id are registered (1 cycle).
// Backpressure: req_ready is a combinational one-hot grant to the first eligible channel from rr_ptr; others wait.
module acc_rr_scheduler #(
   parameter int NUM_CH    = 4,
   parameter int ACC_WIDTH = 16,
   parameter int ADD_WIDTH = 8,
   parameter int SEL_WIDTH = $clog2(NUM_CH)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_CH-1:0]           req_valid,
   input  logic [NUM_CH*ADD_WIDTH-1:0] req_value,
   output logic [NUM_CH-1:0]           req_ready,
   input  logic [NUM_CH-1:0]           clr,
   input  logic [SEL_WIDTH-1:0]        rd_sel,
   output logic [ACC_WIDTH-1:0]        rd_data,
   output logic                        rd_ovf,
   output logic                        grant_valid,
   output logic [SEL_WIDTH-1:0]        grant_id
);

   // Internal channel index width; rd_sel/grant_id may be wider to allow out-of-range selects.
   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [ACC_WIDTH-1:0] acc [NUM_CH];
   logic [NUM_CH-1:0]    ovf;
   logic [IDX_W-1:0]     rr_ptr;

   logic [ADD_WIDTH-1:0] val_arr [NUM_CH];
   logic [NUM_CH-1:0]    elig;
   logic [NUM_CH-1:0]    gnt_oh;
   logic [IDX_W-1:0]     gnt_idx;
   logic                 gnt_any;
   logic [IDX_W:0]       scan_pos;
   logic [ACC_WIDTH:0]   add_sum;
   logic [IDX_W-1:0]     rd_idx;
   logic                 rd_in_range;

   // A channel being cleared this cycle is never eligible for a grant.
   assign elig = req_valid & ~clr;

   // Unpack the flat request value bus into per-channel add operands.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         val_arr[i] = req_value[i*ADD_WIDTH +: ADD_WIDTH];
      end
   end

   // Round-robin scan starting at rr_ptr, wrapping modulo NUM_CH; first eligible channel wins.
   always_comb begin
      gnt_any  = 1'b0;
      gnt_idx  = '0;
      gnt_oh   = '0;
      scan_pos = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         scan_pos = {1'b0, rr_ptr} + (IDX_W+1)'(k);
         if (scan_pos >= (IDX_W+1)'(NUM_CH)) begin
            scan_pos = scan_pos - (IDX_W+1)'(NUM_CH);
         end
         if (!gnt_any && elig[scan_pos[IDX_W-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = scan_pos[IDX_W-1:0];
         end
      end
      if (gnt_any) begin
         gnt_oh[gnt_idx] = 1'b1;
      end
   end

   // Grants are suppressed while reset is asserted so no requester sees a handshake.
   assign req_ready = rst_n ? gnt_oh : '0;

   // Single shared adder, operands muxed by the grant; the extra MSB is the carry-out.
   assign add_sum = {1'b0, acc[gnt_idx]}
                  + {{(ACC_WIDTH+1-ADD_WIDTH){1'b0}}, val_arr[gnt_idx]};

   // Accumulator and sticky overflow update: clear has priority, granted channel takes the sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            acc[i] <= '0;
         end
         ovf <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (clr[i]) begin
               acc[i] <= '0;
               ovf[i] <= 1'b0;
            end else if (gnt_any && (gnt_idx == IDX_W'(i))) begin
               acc[i] <= add_sum[ACC_WIDTH-1:0];
               if (add_sum[ACC_WIDTH]) begin
                  ovf[i] <= 1'b1;
               end
            end
         end
      end
   end

   // Pointer advances past the winner only on a handshake; clears leave it alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr      <= '0;
         grant_valid <= 1'b0;
         grant_id    <= '0;
      end else begin
         grant_valid <= gnt_any;
         if (gnt_any) begin
            rr_ptr   <= (gnt_idx == IDX_W'(NUM_CH-1)) ? '0 : gnt_idx + 1'b1;
            grant_id <= SEL_WIDTH'(gnt_idx);
         end
      end
   end

   assign rd_idx      = rd_sel[IDX_W-1:0];
   assign rd_in_range = (int'(rd_sel) < NUM_CH);

   // Registered readback of pre-update state; out-of-range selects read as zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
         rd_ovf  <= 1'b0;
      end else if (rd_in_range) begin
         rd_data <= acc[rd_idx];
         rd_ovf  <= ovf[rd_idx];
      end else begin
         rd_data <= '0;
         rd_ovf  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_acc_rr_scheduler.sv
// Directed bench for acc_rr_scheduler with a grant scoreboard and accumulator model.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled 1 unit after that.
// Expected grants are queued when requests are driven and popped after the clock edge.
module tb_acc_rr_scheduler;
   localparam int NUM_CH    = 4;
   localparam int ACC_WIDTH = 16;
   localparam int ADD_WIDTH = 8;
   localparam int SEL_WIDTH = 3;

   logic                        clk;
   logic                        rst_n;
   logic [NUM_CH-1:0]           req_valid;
   logic [NUM_CH*ADD_WIDTH-1:0] req_value;
   logic [NUM_CH-1:0]           req_ready;
   logic [NUM_CH-1:0]           clr;
   logic [SEL_WIDTH-1:0]        rd_sel;
   logic [ACC_WIDTH-1:0]        rd_data;
   logic                        rd_ovf;
   logic                        grant_valid;
   logic [SEL_WIDTH-1:0]        grant_id;

   int errors = 0;
   int checks = 0;

   logic [7:0]  vals  [NUM_CH];
   logic [15:0] m_acc [NUM_CH];
   logic [3:0]  m_ovf;
   int          m_ptr;
   int          exp_q [$];
   int          last_gid;

   acc_rr_scheduler #(
      .NUM_CH   (NUM_CH),
      .ACC_WIDTH(ACC_WIDTH),
      .ADD_WIDTH(ADD_WIDTH),
      .SEL_WIDTH(SEL_WIDTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_value  (req_value),
      .req_ready  (req_ready),
      .clr        (clr),
      .rd_sel     (rd_sel),
      .rd_data    (rd_data),
      .rd_ovf     (rd_ovf),
      .grant_valid(grant_valid),
      .grant_id   (grant_id)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) m_acc[i] = '0;
      m_ovf = '0;
      m_ptr = 0;
      exp_q.delete();
   endtask

   // One clock cycle of stimulus: check the combinational grant, queue it, then check the registered grant.
   task automatic cycle(input logic [3:0] v, input logic [3:0] c);
      logic [3:0]  elig;
      logic [3:0]  exp_oh;
      logic [16:0] s;
      int          g;
      req_valid = v;
      clr       = c;
      req_value = {vals[3], vals[2], vals[1], vals[0]};
      #1;
      elig   = v & ~c;
      exp_oh = '0;
      g      = -1;
      for (int k = 0; k < NUM_CH; k++) begin
         if (g < 0 && elig[(m_ptr + k) % NUM_CH]) g = (m_ptr + k) % NUM_CH;
      end
      if (g >= 0) exp_oh[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_oh));
      for (int i = 0; i < NUM_CH; i++) begin
         if (c[i]) begin
            m_acc[i] = '0;
            m_ovf[i] = 1'b0;
         end
      end
      if (g >= 0) begin
         s = {1'b0, m_acc[g]} + {9'b0, vals[g]};
         m_acc[g] = s[15:0];
         if (s[16]) m_ovf[g] = 1'b1;
         m_ptr = (g + 1) % NUM_CH;
         exp_q.push_back(g);
      end
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         last_gid = exp_q.pop_front();
         chk("grant_valid", 32'(grant_valid), 32'd1);
         chk("grant_id", 32'(grant_id), 32'(last_gid));
      end else begin
         last_gid = -1;
         chk("grant_valid_idle", 32'(grant_valid), 32'd0);
      end
   endtask

   // Select a channel, run an idle cycle, then compare the registered readback.
   task automatic rd_check(input string tag, input logic [2:0] sel,
                           input logic [15:0] exp_d, input logic exp_o);
      rd_sel = sel;
      cycle(4'b0000, 4'b0000);
      chk({tag, "_data"}, 32'(rd_data), 32'(exp_d));
      chk({tag, "_ovf"}, 32'(rd_ovf), 32'(exp_o));
      if (int'(sel) < NUM_CH) begin
         chk({tag, "_model"}, 32'(rd_data), 32'(m_acc[sel]));
      end
   endtask

   initial begin
      logic [15:0] old;
      int          got1;
      int          sparse_exp [3];

      // Reset / idle
      rst_n     = 1'b0;
      req_valid = 4'hF;
      clr       = '0;
      rd_sel    = '0;
      for (int i = 0; i < NUM_CH; i++) vals[i] = 8'd1;
      req_value = {vals[3], vals[2], vals[1], vals[0]};
      model_reset();
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      chk("rst_grant_valid", 32'(grant_valid), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hold_req_ready", 32'(req_ready), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_rd_ovf", 32'(rd_ovf), 32'd0);
      rst_n = 1'b1;
      cycle(4'b0000, 4'b0000);
      cycle(4'b0000, 4'b0000);
      chk("idle_rd_data", 32'(rd_data), 32'd0);
      chk("idle_grant_id", 32'(grant_id), 32'd0);

      // Round-robin with all channels valid
      for (int k = 0; k < 8; k++) begin
         cycle(4'b1111, 4'b0000);
         chk("rr_seq", 32'(last_gid), 32'(k % 4));
      end
      for (int ch = 0; ch < NUM_CH; ch++) begin
         rd_check("rr_read", 3'(ch), 16'd2, 1'b0);
      end

      // Sparse: move pointer to 1, then ch2/ch0 alternate
      cycle(4'b0001, 4'b0000);
      chk("sparse_setup", 32'(last_gid), 32'd0);
      sparse_exp = '{2, 0, 2};
      for (int k = 0; k < 3; k++) begin
         cycle(4'b0101, 4'b0000);
         chk("sparse_seq", 32'(last_gid), 32'(sparse_exp[k]));
      end
      got1 = 0;
      for (int w = 0; w < 4; w++) begin
         if (got1 == 0) begin
            cycle(4'b0111, 4'b0000);
            if (last_gid == 1) got1 = 1;
         end
      end
      chk("late_ch1_wait", 32'(got1), 32'd1);

      // Overflow on ch1
      cycle(4'b0000, 4'b0010);
      vals[1] = 8'hFF;
      repeat (257) cycle(4'b0010, 4'b0000);
      rd_check("ovf_pre", 3'd1, 16'hFFFF, 1'b0);
      vals[1] = 8'h01;
      cycle(4'b0010, 4'b0000);
      rd_check("ovf_wrap", 3'd1, 16'h0000, 1'b1);
      vals[1] = 8'h05;
      cycle(4'b0010, 4'b0000);
      rd_check("ovf_sticky", 3'd1, 16'h0005, 1'b1);

      // Clear versus request on ch3
      cycle(4'b0000, 4'b1000);
      vals[3] = 8'h10;
      cycle(4'b1000, 4'b0000);
      rd_check("ch3_pre", 3'd3, 16'h0010, 1'b0);
      cycle(4'b1000, 4'b1000);
      chk("clr_no_grant", 32'(last_gid), 32'hFFFF_FFFF);
      rd_check("ch3_clr", 3'd3, 16'h0000, 1'b0);
      vals[3] = 8'h07;
      cycle(4'b1000, 4'b0000);
      rd_check("ch3_add", 3'd3, 16'h0007, 1'b0);

      // Readback latency and range
      rd_sel  = 3'd0;
      old     = m_acc[0];
      vals[0] = 8'd9;
      cycle(4'b0001, 4'b0000);
      chk("lat_edge_n", 32'(rd_data), 32'(old));
      cycle(4'b0000, 4'b0000);
      chk("lat_edge_n1", 32'(rd_data), 32'(old + 16'd9));
      rd_check("range5", 3'd5, 16'h0000, 1'b0);
      rd_check("range7", 3'd7, 16'h0000, 1'b0);

      // Reset in the middle of traffic
      rd_sel    = 3'd1;
      req_valid = 4'hF;
      clr       = '0;
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_req_ready", 32'(req_ready), 32'd0);
      chk("midrst_grant_valid", 32'(grant_valid), 32'd0);
      chk("midrst_rd_data", 32'(rd_data), 32'd0);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      req_valid = '0;
      model_reset();
      rd_check("post_rst_ch1", 3'd1, 16'h0000, 1'b0);
      cycle(4'b1111, 4'b0000);
      chk("post_rst_first", 32'(last_gid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
